// File: rtl/led_sequencer.sv
// LED output stage for four active-low user LEDs: timed blink/chase/bounce
// patterns with PWM brightness and a valid/ready mode-change port.
module led_sequencer #(
    parameter int TICK_DIV   = 50000,
    parameter int STEP_TICKS = 100,
    parameter int PWM_BITS   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic                mode_valid,
    output logic                mode_ready,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                step_strobe,
    output logic [3:0]          leds
);

    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int STEP_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        M_OFF    = 2'd0,
        M_BLINK  = 2'd1,
        M_CHASE  = 2'd2,
        M_BOUNCE = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    state_t              state;
    state_t              next_state;
    mode_t               mode_q;
    dir_t                dir;
    dir_t                next_dir;
    logic [3:0]          pat;
    logic [3:0]          next_pat;
    logic [PRE_W-1:0]    prescaler;
    logic [STEP_W-1:0]   stepcnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_on;
    logic                accept;
    logic                pre_last;
    logic                step_last;
    logic                advance;

    function automatic logic [3:0] init_pat(input mode_t m);
        case (m)
            M_BLINK:  init_pat = 4'b1111;
            M_CHASE:  init_pat = 4'b0001;
            M_BOUNCE: init_pat = 4'b0001;
            default:  init_pat = 4'b0000;
        endcase
    endfunction

    assign accept    = mode_valid && mode_ready;
    assign pre_last  = (prescaler == PRE_W'(TICK_DIV - 1));
    assign step_last = (stepcnt == STEP_W'(STEP_TICKS - 1));
    // A mode accept on the same edge suppresses the advance entirely.
    assign advance   = (state == S_RUN) && pre_last && step_last && !accept;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        next_state = state;
        case (state)
            S_OFF:   if (accept) next_state = S_LOAD;
            S_LOAD:  next_state = (mode_q == M_OFF) ? S_OFF : S_RUN;
            S_RUN:   if (accept) next_state = S_LOAD;
            default: next_state = S_OFF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state      <= S_OFF;
            mode_q     <= M_OFF;
            mode_ready <= 1'b0;
        end else begin
            state      <= next_state;
            mode_ready <= (next_state != S_LOAD);
            if (accept) mode_q <= mode_t'(mode);
        end
    end

    // Step timing only runs in S_RUN; any accept or other state clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            stepcnt   <= '0;
        end else if (state == S_RUN && !accept) begin
            if (pre_last) begin
                prescaler <= '0;
                stepcnt   <= step_last ? '0 : stepcnt + STEP_W'(1);
            end else begin
                prescaler <= prescaler + PRE_W'(1);
            end
        end else begin
            prescaler <= '0;
            stepcnt   <= '0;
        end
    end

    always_comb begin
        next_pat = pat;
        next_dir = dir;
        case (mode_q)
            M_BLINK: next_pat = ~pat;
            M_CHASE: next_pat = {pat[2:0], pat[3]};
            M_BOUNCE: begin
                next_pat = (dir == DIR_UP) ? {pat[2:0], 1'b0} : {1'b0, pat[3:1]};
                if (next_pat == 4'b1000)      next_dir = DIR_DOWN;
                else if (next_pat == 4'b0001) next_dir = DIR_UP;
            end
            default: next_pat = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat         <= 4'b0000;
            dir         <= DIR_UP;
            step_strobe <= 1'b0;
        end else begin
            step_strobe <= advance;
            if (accept) begin
                pat <= init_pat(mode_t'(mode));
                dir <= DIR_UP;
            end else if (advance) begin
                pat <= next_pat;
                dir <= next_dir;
            end else if (state == S_OFF) begin
                pat <= 4'b0000;
            end
        end
    end

    // All-ones brightness must be fully on, which a plain compare cannot reach.
    assign pwm_on = (brightness == {PWM_BITS{1'b1}}) ? 1'b1 : (pwm_cnt < brightness);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
            leds    <= 4'b1111;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            leds    <= ~(pat & {4{pwm_on}});
        end
    end

endmodule
